// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_pkg
//  Description : Shared definitions for the Manchester decoder: default
//                start-of-frame delimiter, decoder state encoding and the
//                half-bit pair codes (IEEE 802.3 polarity).
//  Revision    : 1.0 - initial release
// ============================================================================
package manchester_pkg;

    // Default start-of-frame delimiter, matched MSB-first on decoded bits
    localparam logic [7:0] c_sfd_default = 8'hD5;

    // Half-bit pairs, oldest half-bit on the left
    localparam logic [1:0] c_pair_one  = 2'b01;
    localparam logic [1:0] c_pair_zero = 2'b10;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/manchester_pair_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_pair_slicer
//  Description : Combinational walk over a work list of up to 4 half-bits.
//                Pairs 01/10 decode to 1/0 and consume two entries; pairs
//                00/11 slip by one entry. The walk is reported as an ordered
//                list of up to 3 events so the caller can sequence state
//                changes between a slip and a decoded bit.
//  Ports       : half_bits  [3:0] in  work list, [0] is the oldest entry
//                half_cnt   [2:0] in  valid entries, 0..4
//                dec_bits   [1:0] out decoded bits, oldest at [dec_cnt-1]
//                dec_cnt    [1:0] out number of decoded bits, 0..2
//                ev_valid   [2:0] out event e occurred (in walk order)
//                ev_slip    [2:0] out event e was a slip
//                ev_bit     [2:0] out decoded bit of event e (non-slip)
//                pend_valid       out one entry left over
//                pend_bit         out value of the left-over entry
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_pair_slicer
    import manchester_pkg::*;
(
    input  logic [3:0] half_bits,
    input  logic [2:0] half_cnt,
    output logic [1:0] dec_bits,
    output logic [1:0] dec_cnt,
    output logic [2:0] ev_valid,
    output logic [2:0] ev_slip,
    output logic [2:0] ev_bit,
    output logic       pend_valid,
    output logic       pend_bit
);

    logic [4:0] w_hb;
    logic [2:0] w_pos;
    logic [1:0] w_pair;

    always_comb begin
        // Padding entry keeps w_pos+1 in range without a guard
        w_hb       = {1'b0, half_bits};
        w_pos      = '0;
        w_pair     = '0;
        dec_bits   = '0;
        dec_cnt    = '0;
        ev_valid   = '0;
        ev_slip    = '0;
        ev_bit     = '0;
        pend_valid = 1'b0;
        pend_bit   = 1'b0;

        // Every event consumes at least one entry, so three steps cover
        // the worst case of four entries (three slips, one left over).
        for (int e = 0; e < 3; e++) begin
            if (w_pos + 3'd2 <= half_cnt) begin
                w_pair      = {w_hb[w_pos], w_hb[w_pos + 3'd1]};
                ev_valid[e] = 1'b1;
                if (w_pair == c_pair_one || w_pair == c_pair_zero) begin
                    ev_bit[e] = (w_pair == c_pair_one);
                    dec_bits  = {dec_bits[0], ev_bit[e]};
                    dec_cnt   = dec_cnt + 2'd1;
                    w_pos     = w_pos + 3'd2;
                end else begin
                    ev_slip[e] = 1'b1;
                    w_pos      = w_pos + 3'd1;
                end
            end
        end

        if (w_pos + 3'd1 == half_cnt) begin
            pend_valid = 1'b1;
            pend_bit   = w_hb[w_pos];
        end
    end

endmodule
`default_nettype wire

// File: rtl/manchester_decoder_2.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_decoder_2
//  Description : Manchester half-bit stream decoder with pair alignment,
//                SFD hunt after a 1010 preamble and MSB-first byte assembly.
//  Ports       : aclk, areset        clock, synchronous active-high reset
//                bits[2:0]           new half-bits, oldest at [num_bits-1]
//                num_bits[2:0]       valid half-bits 0..3 (4..7 => 0)
//                dec_bits/dec_cnt    decoded bits this cycle
//                sfd_found           pulse on delimiter match in HUNT
//                in_frame            level, set by SFD, cleared by violation
//                byte_data/valid     assembled payload byte and its strobe
//                code_err            pulse on 00/11 pair while in frame
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_decoder_2
    import manchester_pkg::*;
#(
    parameter logic [7:0] SFD = c_sfd_default
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [2:0] bits,
    input  logic [2:0] num_bits,
    output logic [1:0] dec_bits,
    output logic [1:0] dec_cnt,
    output logic       sfd_found,
    output logic       in_frame,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       code_err
);

    // State registers
    state_t     r_state;
    logic       r_pend_valid;
    logic       r_pend_bit;
    logic [7:0] r_hist;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;

    // Output registers
    logic [1:0] r_dec_bits;
    logic [1:0] r_dec_cnt;
    logic       r_sfd_found;
    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic       r_code_err;

    // Work list assembly
    logic [2:0] w_nb;
    logic [2:0] w_new;
    logic [3:0] w_hb;
    logic [2:0] w_hcnt;

    // Slicer results
    logic [1:0] w_slc_bits;
    logic [1:0] w_slc_cnt;
    logic [2:0] w_ev_valid;
    logic [2:0] w_ev_slip;
    logic [2:0] w_ev_bit;
    logic       w_pend_valid;
    logic       w_pend_bit;

    // Next-state and event signals
    state_t     w_state_nxt;
    logic [7:0] w_hist_nxt;
    logic [2:0] w_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_sfd_hit;
    logic       w_byte_hit;
    logic [7:0] w_byte_val;
    logic       w_err_hit;

    // Next output values
    logic [1:0] w_dec_bits_nxt;
    logic [1:0] w_dec_cnt_nxt;
    logic       w_sfd_nxt;
    logic [7:0] w_bd_nxt;
    logic       w_bv_nxt;
    logic       w_err_nxt;

    // Reorder new half-bits oldest-first and prepend the pending one
    always_comb begin
        w_nb  = (num_bits > 3'd3) ? 3'd0 : num_bits;
        w_new = '0;
        case (w_nb)
            3'd1:    w_new = {2'b00, bits[0]};
            3'd2:    w_new = {1'b0, bits[0], bits[1]};
            3'd3:    w_new = {bits[0], bits[1], bits[2]};
            default: w_new = '0;
        endcase
        w_hb   = r_pend_valid ? {w_new, r_pend_bit} : {1'b0, w_new};
        w_hcnt = w_nb + {2'b00, r_pend_valid};
    end

    manchester_pair_slicer u_slicer (
        .half_bits  (w_hb),
        .half_cnt   (w_hcnt),
        .dec_bits   (w_slc_bits),
        .dec_cnt    (w_slc_cnt),
        .ev_valid   (w_ev_valid),
        .ev_slip    (w_ev_slip),
        .ev_bit     (w_ev_bit),
        .pend_valid (w_pend_valid),
        .pend_bit   (w_pend_bit)
    );

    // Next-state: apply walk events in order, so a slip after an SFD match
    // or a payload bit after an SFD match land in the right state.
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_sfd_hit   = 1'b0;
        w_byte_hit  = 1'b0;
        w_byte_val  = '0;
        w_err_hit   = 1'b0;

        for (int e = 0; e < 3; e++) begin
            if (w_ev_valid[e]) begin
                if (w_ev_slip[e]) begin
                    // Silent in HUNT: that is how alignment is found
                    if (w_state_nxt == FRAME) begin
                        w_err_hit   = 1'b1;
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_hist_nxt = {w_hist_nxt[6:0], w_ev_bit[e]};
                    if (w_state_nxt == HUNT) begin
                        if (w_hist_nxt == SFD) begin
                            w_sfd_hit   = 1'b1;
                            w_state_nxt = FRAME;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_shift_nxt = {w_shift_nxt[6:0], w_ev_bit[e]};
                        if (w_cnt_nxt == 3'd7) begin
                            w_byte_hit = 1'b1;
                            w_byte_val = w_shift_nxt;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_nxt + 3'd1;
                        end
                    end
                end
            end
        end
    end

    // Output values to be registered
    always_comb begin
        w_dec_bits_nxt = w_slc_bits;
        w_dec_cnt_nxt  = w_slc_cnt;
        w_sfd_nxt      = w_sfd_hit;
        w_bv_nxt       = w_byte_hit;
        w_bd_nxt       = w_byte_hit ? w_byte_val : r_byte_data;
        w_err_nxt      = w_err_hit;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= HUNT;
            r_pend_valid <= 1'b0;
            r_pend_bit   <= 1'b0;
            r_hist       <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_dec_bits   <= '0;
            r_dec_cnt    <= '0;
            r_sfd_found  <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_code_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid;
            r_pend_bit   <= w_pend_bit;
            r_hist       <= w_hist_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_dec_bits   <= w_dec_bits_nxt;
            r_dec_cnt    <= w_dec_cnt_nxt;
            r_sfd_found  <= w_sfd_nxt;
            r_byte_data  <= w_bd_nxt;
            r_byte_valid <= w_bv_nxt;
            r_code_err   <= w_err_nxt;
        end
    end

    assign dec_bits   = r_dec_bits;
    assign dec_cnt    = r_dec_cnt;
    assign sfd_found  = r_sfd_found;
    assign in_frame   = (r_state == FRAME);
    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign code_err   = r_code_err;

endmodule
`default_nettype wire

// File: tb/tb_manchester_decoder_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_manchester_decoder_2
//  Description : Directed self-checking bench for manchester_decoder_2.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_manchester_decoder_2;

    logic       aclk = 1'b0;
    logic       areset;
    logic [2:0] bits;
    logic [2:0] num_bits;
    logic [1:0] dec_bits;
    logic [1:0] dec_cnt;
    logic       sfd_found;
    logic       in_frame;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       code_err;

    manchester_decoder_2 #(.SFD(8'hD5)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .bits       (bits),
        .num_bits   (num_bits),
        .dec_bits   (dec_bits),
        .dec_cnt    (dec_cnt),
        .sfd_found  (sfd_found),
        .in_frame   (in_frame),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .code_err   (code_err)
    );

    always #5 aclk = ~aclk;

    int         n_vec = 0;
    int         n_err = 0;
    int         in_cyc;
    bit         mon_en = 1'b0;
    int         sfd_n, sfd_cyc, err_n, max_cnt;
    logic       err_inframe;
    logic [7:0] byte_q[$];
    int         byte_cyc_q[$];
    logic       dec_q[$];
    logic       hq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge aclk) begin
        if (mon_en) begin
            if (int'(dec_cnt) > max_cnt) max_cnt = int'(dec_cnt);
            if (dec_cnt == 2'd2) begin
                dec_q.push_back(dec_bits[1]);
                dec_q.push_back(dec_bits[0]);
            end else if (dec_cnt == 2'd1) begin
                dec_q.push_back(dec_bits[0]);
            end
            if (sfd_found) begin
                sfd_n++;
                sfd_cyc = in_cyc;
            end
            if (byte_valid) begin
                byte_q.push_back(byte_data);
                byte_cyc_q.push_back(in_cyc);
            end
            if (code_err) begin
                err_n++;
                err_inframe = in_frame;
            end
        end
    end

    task automatic clear_mon();
        in_cyc = 0; sfd_n = 0; sfd_cyc = -1; err_n = 0; max_cnt = 0;
        err_inframe = 1'bx;
        byte_q.delete(); byte_cyc_q.delete(); dec_q.delete(); hq.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1; num_bits = '0; bits = '0;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    // Encode nb bits of v, MSB-first, as half-bits (1 -> 0,1 ; 0 -> 1,0)
    task automatic enc(input logic [7:0] v, input int nb);
        logic b;
        for (int i = 0; i < nb; i++) begin
            b = v[7];
            v = {v[6:0], 1'b0};
            hq.push_back(~b);
            hq.push_back(b);
        end
    endtask

    task automatic enc_stream();
        enc(8'hAA, 8); enc(8'hAA, 8); enc(8'hD5, 8);
        enc(8'hAA, 8); enc(8'hBB, 8); enc(8'hCC, 8); enc(8'hDD, 8);
    endtask

    // Drive the half-bit queue; upper unused bits are left at 1
    task automatic feed(input int mode);
        int         k;
        int         n;
        int         pat[6];
        logic [2:0] bv;
        pat = '{3, 0, 1, 2, 3, 3};
        k = 0;
        while (hq.size() > 0) begin
            case (mode)
                0:       n = (k == 0) ? 3 : ((k == 1) ? 1 : 2);
                1:       n = 2;
                default: n = pat[k % 6];
            endcase
            if (n > hq.size()) n = hq.size();
            bv = 3'b111;
            for (int j = 0; j < n; j++) bv = {bv[1:0], hq.pop_front()};
            bits = bv; num_bits = 3'(n);
            @(posedge aclk); in_cyc++; #1;
            k++;
        end
        num_bits = '0; bits = '0;
    endtask

    // Idle cycles with an out-of-range count that must act as zero
    task automatic idle(input int n);
        num_bits = 3'd7; bits = 3'b101;
        repeat (n) begin
            @(posedge aclk); in_cyc++; #1;
        end
        num_bits = '0; bits = '0;
    endtask

    task automatic check_bytes(input string p);
        logic [7:0] exp_b[4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk({p, "_nbytes"}, byte_q.size(), 4);
        for (int i = 0; i < 4 && i < byte_q.size(); i++)
            chk($sformatf("%s_byte%0d", p, i), byte_q[i], exp_b[i]);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_dec_bits"},   dec_bits,   0);
        chk({p, "_dec_cnt"},    dec_cnt,    0);
        chk({p, "_sfd_found"},  sfd_found,  0);
        chk({p, "_in_frame"},   in_frame,   0);
        chk({p, "_byte_data"},  byte_data,  0);
        chk({p, "_byte_valid"}, byte_valid, 0);
        chk({p, "_code_err"},   code_err,   0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pre;
        areset = 1'b1; bits = '0; num_bits = '0;
        clear_mon();
        @(posedge aclk); #1;
        do_reset();
        @(negedge aclk);
        check_zero("rst");
        mon_en = 1'b1;

        // Aligned preamble + SFD + payload, rates 3,1,2,2...
        clear_mon();
        enc_stream();
        feed(0);
        idle(3);
        chk("s1_sfd_n", sfd_n, 1);
        chk("s1_sfd_cyc", sfd_cyc, 24);
        chk("s1_code_err", err_n, 0);
        chk("s1_in_frame", in_frame, 1);
        chk("s1_max_cnt_le2", max_cnt <= 2, 1);
        chk("s1_dec_len", dec_q.size(), 56);
        pre = '0;
        for (int i = 0; i < 24 && i < dec_q.size(); i++) pre = {pre[22:0], dec_q[i]};
        chk("s1_dec_prefix", pre, 24'hAAAAD5);
        check_bytes("s1");
        for (int i = 0; i < 4 && i < byte_cyc_q.size(); i++)
            chk($sformatf("s1_bcyc%0d", i), byte_cyc_q[i], 32 + 8 * i);

        // Misaligned by one leading half-bit
        do_reset();
        clear_mon();
        hq.push_back(1'b1);
        enc_stream();
        feed(1);
        idle(3);
        chk("s3_sfd_n", sfd_n, 1);
        chk("s3_code_err", err_n, 0);
        chk("s3_in_frame", in_frame, 1);
        check_bytes("s3");

        // Mixed rates 3,0,1,2,3,3
        do_reset();
        clear_mon();
        enc_stream();
        feed(2);
        idle(3);
        chk("s4_sfd_n", sfd_n, 1);
        chk("s4_code_err", err_n, 0);
        chk("s4_max_cnt_le2", max_cnt <= 2, 1);
        check_bytes("s4");

        // Violation in frame, then re-acquire
        do_reset();
        clear_mon();
        enc(8'hAA, 8); enc(8'hAA, 8); enc(8'hD5, 8);
        enc(8'hA0, 4);
        hq.push_back(1'b1); hq.push_back(1'b1);
        enc(8'hAA, 8); enc(8'hAA, 8); enc(8'hD5, 8); enc(8'h3C, 8);
        feed(1);
        idle(3);
        chk("s5_code_err_n", err_n, 1);
        chk("s5_in_frame_at_err", err_inframe, 0);
        chk("s5_sfd_n", sfd_n, 2);
        chk("s5_nbytes", byte_q.size(), 1);
        if (byte_q.size() > 0) chk("s5_byte0", byte_q[0], 8'h3C);
        chk("s5_in_frame_end", in_frame, 1);

        // Reset mid-frame after 4 payload bits
        do_reset();
        clear_mon();
        enc(8'hAA, 8); enc(8'hAA, 8); enc(8'hD5, 8);
        enc(8'hA0, 4);
        feed(1);
        chk("s6_in_frame_pre", in_frame, 1);
        do_reset();
        @(negedge aclk);
        check_zero("s6_rst");
        enc(8'h50, 4);
        feed(1);
        idle(3);
        chk("s6_nbytes", byte_q.size(), 0);
        chk("s6_code_err", err_n, 0);
        chk("s6_in_frame_end", in_frame, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
